// File: rtl/aidc_lite_pkg.sv
// Shared AIDC-Lite widths and the code-split FSM state type.
package aidc_lite_pkg;

    localparam int unsigned AIDC_LITE_PREFIX_W   = 2;
    localparam int unsigned AIDC_LITE_WORD_W     = 64;
    localparam int unsigned AIDC_LITE_BLK_SIZE_W = 11;
    localparam int unsigned AIDC_LITE_SIZE_W     = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } split_state_e;

endpackage

// File: rtl/aidc_lite_code_split_bit_buf.sv
// MSB-aligned bit buffer: shift out consumed bits, then append a word at the fill level.
module aidc_lite_bit_buf
    import aidc_lite_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 66,
    parameter int unsigned BUF_SIZE  = 128,
    parameter int unsigned FILL_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        load,
    input  logic                        append,
    input  logic                        shift,
    input  logic [AIDC_LITE_SIZE_W-1:0] size,
    input  logic [AIDC_LITE_WORD_W-1:0] data,
    output logic [DATA_SIZE-1:0]        window,
    output logic [FILL_W-1:0]           fill
);

    localparam int unsigned PAD_W   = BUF_SIZE - AIDC_LITE_WORD_W;
    localparam int unsigned BODY_W  = AIDC_LITE_WORD_W - AIDC_LITE_PREFIX_W;
    localparam int unsigned LPAD_W  = BUF_SIZE - BODY_W;

    logic [BUF_SIZE-1:0] buf_q;
    logic [BUF_SIZE-1:0] buf_d;
    logic [BUF_SIZE-1:0] shifted;
    logic [BUF_SIZE-1:0] word_ext;
    logic [FILL_W-1:0]   fill_q;
    logic [FILL_W-1:0]   fill_d;
    logic [FILL_W-1:0]   fill_s;

    // Shift happens before append so a same-cycle word lands at the post-shift fill.
    always_comb begin
        shifted = buf_q;
        fill_s  = fill_q;
        if (shift) begin
            shifted = buf_q << size;
            fill_s  = (FILL_W'(size) > fill_q) ? '0 : fill_q - FILL_W'(size);
        end
        word_ext = {data, {PAD_W{1'b0}}} >> fill_s;

        buf_d  = shifted;
        fill_d = fill_s;
        if (clr) begin
            buf_d  = '0;
            fill_d = '0;
        end else if (load) begin
            buf_d  = {data[BODY_W-1:0], {LPAD_W{1'b0}}};
            fill_d = FILL_W'(BODY_W);
        end else if (append) begin
            buf_d  = shifted | word_ext;
            fill_d = fill_s + FILL_W'(AIDC_LITE_WORD_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    assign window = buf_q[BUF_SIZE-1 -: DATA_SIZE];
    assign fill   = fill_q;

endmodule

// File: rtl/aidc_lite_code_split.sv
// Splits one compressed block into decoder code windows; prefix check under
// AIDC_LITE_SPLIT_PREFIX_CHK_EN (otherwise the prefix is stripped unchecked).
module aidc_lite_code_split
    import aidc_lite_pkg::*;
#(
    parameter logic [AIDC_LITE_PREFIX_W-1:0] PREFIX    = 2'b00,
    parameter int unsigned                   DATA_SIZE = 66,
    parameter int unsigned                   BUF_SIZE  = 128
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_i,
    output logic                            ready_o,
    input  logic [AIDC_LITE_WORD_W-1:0]     data_i,
    input  logic                            last_i,
    output logic                            code_valid_o,
    output logic [DATA_SIZE-1:0]            code_o,
    input  logic                            consume_i,
    input  logic [AIDC_LITE_SIZE_W-1:0]     size_i,
    input  logic                            eob_i,
    output logic                            done_o,
    output logic [AIDC_LITE_BLK_SIZE_W-1:0] blk_size_o,
    output logic                            prefix_err_o
);

    localparam int unsigned FILL_W = $clog2(BUF_SIZE + 1);
    localparam int unsigned BLK_W  = AIDC_LITE_BLK_SIZE_W;

    split_state_e      state_q;
    split_state_e      state_d;
    logic              last_seen_q;
    logic              last_seen_d;
    logic [BLK_W-1:0]  blk_size_q;
    logic [BLK_W-1:0]  blk_size_d;
    logic              prefix_err_q;
    logic              prefix_err_d;
    logic              prefix_mis;
    logic              accept;
    logic              consume;
    logic              buf_load;
    logic              buf_append;
    logic              buf_clr;
    logic [FILL_W-1:0] fill;

`ifdef AIDC_LITE_SPLIT_PREFIX_CHK_EN
    assign prefix_mis = data_i[AIDC_LITE_WORD_W-1 -: AIDC_LITE_PREFIX_W] != PREFIX;
`else
    logic unused_prefix;
    assign prefix_mis    = 1'b0;
    assign unused_prefix = ^{data_i[AIDC_LITE_WORD_W-1 -: AIDC_LITE_PREFIX_W], PREFIX};
`endif

    always_comb begin
        ready_o      = 1'b0;
        code_valid_o = 1'b0;
        done_o       = 1'b0;
        state_d      = state_q;
        last_seen_d  = last_seen_q;
        blk_size_d   = blk_size_q;
        prefix_err_d = prefix_err_q;
        buf_load     = 1'b0;
        buf_append   = 1'b0;
        buf_clr      = 1'b0;

        // Handshake outputs depend only on registered state.
        unique case (state_q)
            IDLE:  ready_o = 1'b1;
            RUN: begin
                ready_o      = (fill <= FILL_W'(BUF_SIZE - AIDC_LITE_WORD_W)) && !last_seen_q;
                code_valid_o = (fill >= FILL_W'(DATA_SIZE)) || (last_seen_q && (fill != '0));
            end
            FLUSH: ready_o = 1'b1;
            DONE:  done_o  = 1'b1;
        endcase

        accept  = valid_i && ready_o;
        consume = consume_i && code_valid_o;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_load     = 1'b1;
                    last_seen_d  = last_i;
                    prefix_err_d = prefix_mis;
                    state_d      = RUN;
                end
            end
            RUN: begin
                buf_append = accept;
                if (accept && last_i) begin
                    last_seen_d = 1'b1;
                end
                if (consume) begin
                    blk_size_d = blk_size_q + BLK_W'(size_i);
                    if (eob_i) begin
                        state_d = (last_seen_q || (accept && last_i)) ? DONE : FLUSH;
                    end else if (last_seen_q && (FILL_W'(size_i) >= fill)) begin
                        state_d = DONE;
                    end
                end
            end
            FLUSH: begin
                buf_clr = 1'b1;
                if (accept && last_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                buf_clr     = 1'b1;
                last_seen_d = 1'b0;
                blk_size_d  = BLK_W'(AIDC_LITE_PREFIX_W);
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_seen_q  <= 1'b0;
            blk_size_q   <= BLK_W'(AIDC_LITE_PREFIX_W);
            prefix_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_seen_q  <= last_seen_d;
            blk_size_q   <= blk_size_d;
            prefix_err_q <= prefix_err_d;
        end
    end

    // Decoder must not consume past the end of the final word, nor outside 1..DATA_SIZE.
    always_ff @(posedge clk) begin
        if (!rst && consume) begin
            assert (!last_seen_q || (FILL_W'(size_i) <= fill));
            assert ((size_i != '0) && (32'(size_i) <= DATA_SIZE));
        end
    end

    aidc_lite_bit_buf #(
        .DATA_SIZE (DATA_SIZE),
        .BUF_SIZE  (BUF_SIZE),
        .FILL_W    (FILL_W)
    ) u_bit_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (buf_clr),
        .load   (buf_load),
        .append (buf_append),
        .shift  (consume),
        .size   (size_i),
        .data   (data_i),
        .window (code_o),
        .fill   (fill)
    );

    assign blk_size_o   = blk_size_q;
    assign prefix_err_o = prefix_err_q;

endmodule

// File: tb/tb_aidc_lite_code_split.sv
// Directed vector bench for aidc_lite_code_split.
module tb_aidc_lite_code_split;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] data_i;
    logic        last_i;
    logic        code_valid_o;
    logic [65:0] code_o;
    logic        consume_i;
    logic [6:0]  size_i;
    logic        eob_i;
    logic        done_o;
    logic [10:0] blk_size_o;
    logic        prefix_err_o;

    int checks = 0;
    int errors = 0;

`ifdef AIDC_LITE_SPLIT_PREFIX_CHK_EN
    localparam logic PE = 1'b1;
`else
    localparam logic PE = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        valid;
        logic [63:0] data;
        logic        last;
        logic        consume;
        logic [6:0]  size;
        logic        eob;
        logic        ready;
        logic        cv;
        logic        done;
        logic        perr;
        logic [10:0] blk;
        logic [65:0] code;
        int          code_w;
    } vec_t;

    vec_t vecs[$];

    aidc_lite_code_split dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .last_i       (last_i),
        .code_valid_o (code_valid_o),
        .code_o       (code_o),
        .consume_i    (consume_i),
        .size_i       (size_i),
        .eob_i        (eob_i),
        .done_o       (done_o),
        .blk_size_o   (blk_size_o),
        .prefix_err_o (prefix_err_o)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic vl, input logic [63:0] d, input logic l,
                       input logic cs, input logic [6:0] sz, input logic eb,
                       input logic er, input logic ecv, input logic edn, input logic epe,
                       input logic [10:0] eblk, input logic [65:0] ecode, input int ew);
        vec_t v;
        v.rst = r; v.valid = vl; v.data = d; v.last = l;
        v.consume = cs; v.size = sz; v.eob = eb;
        v.ready = er; v.cv = ecv; v.done = edn; v.perr = epe;
        v.blk = eblk; v.code = ecode; v.code_w = ew;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic send_word(input logic [63:0] d, input logic l);
        int n = 0;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        while (!ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("seq_ready", n, 66'(ready_o), 66'(1'b1));
        @(negedge clk);
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    initial begin
        logic [63:0]  wa, wb0, wb1, wc0, wc1, wc2, wc3;
        logic [63:0]  wd0, wd1, wd2, wd3, wf0, we0, we1, we2, h0, h1;
        logic [5:0]   c0;
        logic [33:0]  c1, c2, c3;
        logic [17:0]  c4;
        logic [125:0] sb, hs;
        logic [65:0]  m;
        int           n;

        rst = 1'b1; valid_i = 1'b0; data_i = '0; last_i = 1'b0;
        consume_i = 1'b0; size_i = '0; eob_i = 1'b0;

        wa  = 64'h3FFF_FFFF_FFFF_FFFF;
        c0  = 6'h2D;
        c1  = 34'h2_1234_5678;
        c2  = 34'h1_DEAD_BEEF;
        c3  = 34'h3_CAFE_F00D;
        c4  = 18'h2_5A5A;
        sb  = {c0, c1, c2, c3, c4};
        wb0 = {2'b00, sb[125:64]};
        wb1 = sb[63:0];
        wc0 = 64'h0123_4567_89AB_CDEF;
        wc1 = 64'hFEDC_BA98_7654_3210;
        wc2 = 64'hA5A5_0F0F_C3C3_9696;
        wc3 = 64'h1357_9BDF_2468_ACE0;
        wd0 = 64'h2222_3333_4444_5555;
        wd1 = 64'h6666_7777_8888_9999;
        wd2 = 64'hAAAA_BBBB_CCCC_DDDD;
        wd3 = 64'hEEEE_FFFF_0000_1111;
        wf0 = 64'h1111_2222_3333_4444;
        we0 = 64'h8000_0000_0000_00FF;
        we1 = 64'h0FED_CBA9_8765_4321;
        we2 = 64'hCCCC_DDDD_EEEE_FFFF;
        h0  = 64'h0A0B_0C0D_0E0F_1011;
        h1  = 64'h1213_1415_1617_1819;

        //   rst vl data last cs size eob | rdy cv done perr blk code width
        // single-word block, good prefix
        add(0, 1, wa,  1, 0,  0, 0,  1, 0, 0, 0,   2, 66'd0, 66);
        add(0, 0, 0,   0, 1, 62, 0,  0, 1, 0, 0,   2, {wa[61:0], 4'b0}, 66);
        add(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0,  64, 66'd0, 66);
        // two-word code stream
        add(0, 1, wb0, 0, 0,  0, 0,  1, 0, 0, 0,   2, 66'd0, 66);
        add(0, 1, wb1, 1, 0,  0, 0,  1, 0, 0, 0,   2, {wb0[61:0], 4'b0}, 66);
        add(0, 0, 0,   0, 1,  6, 0,  0, 1, 0, 0,   2, {c0, 60'b0}, 6);
        add(0, 0, 0,   0, 1, 34, 0,  0, 1, 0, 0,   8, {c1, 32'b0}, 34);
        add(0, 0, 0,   0, 1, 34, 0,  0, 1, 0, 0,  42, {c2, 32'b0}, 34);
        add(0, 0, 0,   0, 1, 34, 0,  0, 1, 0, 0,  76, {c3, c4, 14'b0}, 66);
        add(0, 0, 0,   0, 1, 18, 1,  0, 1, 0, 0, 110, {c4, 48'b0}, 66);
        add(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, 128, 66'd0, 66);
        // back-pressure; consume at fill 64 is ignored since the window is not valid
        add(0, 1, wc0, 0, 0,  0, 0,  1, 0, 0, 0,   2, 66'd0, 66);
        add(0, 1, wc1, 0, 0,  0, 0,  1, 0, 0, 0,   2, {wc0[61:0], 4'b0}, 66);
        add(0, 1, wc2, 0, 1, 56, 0,  0, 1, 0, 0,   2, {wc0[61:0], wc1[63:60]}, 66);
        add(0, 1, wc2, 0, 1,  6, 0,  0, 1, 0, 0,  58, {wc0[5:0], wc1[63:4]}, 66);
        add(0, 1, wc2, 0, 1, 34, 0,  1, 0, 0, 0,  64, {wc1, 2'b0}, 66);
        add(0, 0, 0,   0, 1, 66, 0,  0, 1, 0, 0,  64, {wc1, wc2[63:62]}, 66);
        add(0, 1, wc3, 1, 0,  0, 0,  1, 0, 0, 0, 130, {wc2[61:0], 4'b0}, 66);
        add(0, 0, 0,   0, 1, 66, 1,  0, 1, 0, 0, 130, {wc2[61:0], wc3[63:60]}, 66);
        add(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0, 196, {wc3[59:0], 6'b0}, 66);
        // early eob, flush, then a clean next block
        add(0, 1, wd0, 0, 0,  0, 0,  1, 0, 0, 0,   2, 66'd0, 66);
        add(0, 1, wd1, 0, 0,  0, 0,  1, 0, 0, 0,   2, {wd0[61:0], 4'b0}, 66);
        add(0, 0, 0,   0, 1, 66, 1,  0, 1, 0, 0,   2, {wd0[61:0], wd1[63:60]}, 66);
        add(0, 1, wd2, 0, 0,  0, 0,  1, 0, 0, 0,  68, 66'd0, 0);
        add(0, 1, wd3, 1, 0,  0, 0,  1, 0, 0, 0,  68, 66'd0, 0);
        add(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0,  68, 66'd0, 66);
        add(0, 1, wf0, 1, 0,  0, 0,  1, 0, 0, 0,   2, 66'd0, 66);
        add(0, 0, 0,   0, 1, 62, 0,  0, 1, 0, 0,   2, {wf0[61:0], 4'b0}, 66);
        add(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, 0,  64, 66'd0, 66);
        // bad prefix, sticky flag, clear on next accept, reset mid-block
        add(0, 1, we0, 1, 0,  0, 0,  1, 0, 0, 0,   2, 66'd0, 66);
        add(0, 0, 0,   0, 1, 62, 0,  0, 1, 0, PE,  2, {we0[61:0], 4'b0}, 66);
        add(0, 0, 0,   0, 0,  0, 0,  0, 0, 1, PE, 64, 66'd0, 66);
        add(0, 1, we1, 0, 0,  0, 0,  1, 0, 0, PE,  2, 66'd0, 66);
        add(0, 1, we2, 0, 0,  0, 0,  1, 0, 0, 0,   2, {we1[61:0], 4'b0}, 66);
        add(0, 0, 0,   0, 1, 10, 0,  0, 1, 0, 0,   2, {we1[61:0], we2[63:60]}, 66);
        add(1, 0, 0,   0, 1, 10, 0,  0, 1, 0, 0,  12, {we1[51:0], we2[63:50]}, 66);
        add(0, 0, 0,   0, 0,  0, 0,  1, 0, 0, 0,   2, 66'd0, 66);

        repeat (3) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            chk("ready", i, 66'(ready_o), 66'(vecs[i].ready));
            chk("code_valid", i, 66'(code_valid_o), 66'(vecs[i].cv));
            chk("done", i, 66'(done_o), 66'(vecs[i].done));
            chk("prefix_err", i, 66'(prefix_err_o), 66'(vecs[i].perr));
            chk("blk_size", i, 66'(blk_size_o), 66'(vecs[i].blk));
            if (vecs[i].code_w > 0) begin
                m = ~66'd0 << (66 - vecs[i].code_w);
                chk("code", i, code_o & m, vecs[i].code & m);
            end
            rst       = vecs[i].rst;
            valid_i   = vecs[i].valid;
            data_i    = vecs[i].data;
            last_i    = vecs[i].last;
            consume_i = vecs[i].consume;
            size_i    = vecs[i].size;
            eob_i     = vecs[i].eob;
        end

        // handshake-driven block: six 21-bit codes across two words
        send_word(h0, 1'b0);
        send_word(h1, 1'b1);
        hs = {h0[61:0], h1};
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!code_valid_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("seq_code_valid", k, 66'(code_valid_o), 66'(1'b1));
            chk("seq_code", k, 66'(code_o[65:45]), 66'(hs[125 - 21 * k -: 21]));
            consume_i = 1'b1;
            size_i    = 7'd21;
            eob_i     = (k == 5);
            @(negedge clk);
            consume_i = 1'b0;
            eob_i     = 1'b0;
        end
        chk("seq_done", 0, 66'(done_o), 66'(1'b1));
        chk("seq_blk_size", 0, 66'(blk_size_o), 66'(11'd128));
        @(negedge clk);
        chk("seq_idle_blk", 0, 66'(blk_size_o), 66'(11'd2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
